// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - RV32I ID->EX operand fetch, forwarding and load-use stall stage
//
// Purpose:
//   Drives the register bank read ports and resolves x0. Forwards EX and MEM
//   results, with EX taking priority. Holds the pipeline on a load-use hazard.
//   Captures operands, rd and immediate into a valid/ready slot that EX consumes.
//   WB needs no forwarding path because the bank writes on the falling edge,
//   so the WB value is already visible on rdata1/rdata2.
//
// Ports:
//   clock, reset                  rising-edge clock, async active-high reset
//   flush                         kills the output slot and drops the input beat
//   in_valid/in_ready             decoded instruction handshake
//   in_rs1/in_rs2/in_rd/in_rd_we  register fields of the incoming instruction
//   in_is_load/in_imm             load flag and sign-extended immediate
//   read_addr1/2, rdata1/2        combinational register bank read port
//   ex_we/ex_rd/ex_is_load/ex_data  EX-stage result and forwarding info
//   mem_we/mem_rd/mem_data        MEM-stage result and forwarding info
//   out_valid/out_ready           output slot handshake toward EX
//   out_op1/out_op2/out_rd/out_rd_we/out_is_load/out_imm  registered slot contents
//   stall_count                   saturating count of load-use stall cycles
module operand_fetch_stage #(
   parameter int XLEN        = 32,
   parameter int AW          = 5,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AW-1:0]          in_rs1,
   input  logic [AW-1:0]          in_rs2,
   input  logic [AW-1:0]          in_rd,
   input  logic                   in_rd_we,
   input  logic                   in_is_load,
   input  logic [XLEN-1:0]        in_imm,
   output logic [AW-1:0]          read_addr1,
   output logic [AW-1:0]          read_addr2,
   input  logic [XLEN-1:0]        rdata1,
   input  logic [XLEN-1:0]        rdata2,
   input  logic                   ex_we,
   input  logic [AW-1:0]          ex_rd,
   input  logic                   ex_is_load,
   input  logic [XLEN-1:0]        ex_data,
   input  logic                   mem_we,
   input  logic [AW-1:0]          mem_rd,
   input  logic [XLEN-1:0]        mem_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [XLEN-1:0]        out_op1,
   output logic [XLEN-1:0]        out_op2,
   output logic [AW-1:0]          out_rd,
   output logic                   out_rd_we,
   output logic                   out_is_load,
   output logic [XLEN-1:0]        out_imm,
   output logic [STALL_CNT_W-1:0] stall_count
);

   logic                   valid_q, valid_d;
   logic [XLEN-1:0]        op1_q, op1_d;
   logic [XLEN-1:0]        op2_q, op2_d;
   logic [AW-1:0]          rd_q, rd_d;
   logic                   rd_we_q, rd_we_d;
   logic                   is_load_q, is_load_d;
   logic [XLEN-1:0]        imm_q, imm_d;
   logic [STALL_CNT_W-1:0] stall_q, stall_d;

   logic [XLEN-1:0]        op1_res, op2_res;
   logic                   hazard;
   logic                   accept;

   // A load in EX has no data yet, so it is excluded from the EX forward;
   // the hazard logic holds the consumer until the value reaches MEM.
   function automatic logic [XLEN-1:0] resolve(
      input logic [AW-1:0]   rs,
      input logic [XLEN-1:0] bank_data,
      input logic            f_ex_we,
      input logic [AW-1:0]   f_ex_rd,
      input logic            f_ex_is_load,
      input logic [XLEN-1:0] f_ex_data,
      input logic            f_mem_we,
      input logic [AW-1:0]   f_mem_rd,
      input logic [XLEN-1:0] f_mem_data
   );
      logic [XLEN-1:0] r;
      if (rs == '0)
         r = '0;
      else if (f_ex_we && f_ex_rd == rs && !f_ex_is_load)
         r = f_ex_data;
      else if (f_mem_we && f_mem_rd == rs)
         r = f_mem_data;
      else
         r = bank_data;
      return r;
   endfunction

   assign read_addr1 = in_rs1;
   assign read_addr2 = in_rs2;

   assign op1_res = resolve(in_rs1, rdata1, ex_we, ex_rd, ex_is_load, ex_data,
                            mem_we, mem_rd, mem_data);
   assign op2_res = resolve(in_rs2, rdata2, ex_we, ex_rd, ex_is_load, ex_data,
                            mem_we, mem_rd, mem_data);

   assign hazard   = in_valid && ex_we && ex_is_load && (ex_rd != '0) &&
                     ((ex_rd == in_rs1) || (ex_rd == in_rs2));
   assign in_ready = !flush && !hazard && (!valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      valid_d   = valid_q;
      op1_d     = op1_q;
      op2_d     = op2_q;
      rd_d      = rd_q;
      rd_we_d   = rd_we_q;
      is_load_d = is_load_q;
      imm_d     = imm_q;
      stall_d   = stall_q;

      // accept already implies !flush through in_ready
      if (flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d   = 1'b1;
         op1_d     = op1_res;
         op2_d     = op2_res;
         rd_d      = in_rd;
         rd_we_d   = in_rd_we;
         is_load_d = in_is_load;
         imm_d     = in_imm;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end

      if (hazard && (stall_q != '1))
         stall_d = stall_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q   <= 1'b0;
         op1_q     <= '0;
         op2_q     <= '0;
         rd_q      <= '0;
         rd_we_q   <= 1'b0;
         is_load_q <= 1'b0;
         imm_q     <= '0;
         stall_q   <= '0;
      end else begin
         valid_q   <= valid_d;
         op1_q     <= op1_d;
         op2_q     <= op2_d;
         rd_q      <= rd_d;
         rd_we_q   <= rd_we_d;
         is_load_q <= is_load_d;
         imm_q     <= imm_d;
         stall_q   <= stall_d;
      end
   end

   assign out_valid   = valid_q;
   assign out_op1     = op1_q;
   assign out_op2     = op2_q;
   assign out_rd      = rd_q;
   assign out_rd_we   = rd_we_q;
   assign out_is_load = is_load_q;
   assign out_imm     = imm_q;
   assign stall_count = stall_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb/tb_operand_fetch_stage.sv - scoreboard bench for operand_fetch_stage
module tb_operand_fetch_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rs1, in_rs2, in_rd;
   logic        in_rd_we, in_is_load;
   logic [31:0] in_imm;
   logic [4:0]  read_addr1, read_addr2;
   logic [31:0] rdata1, rdata2;
   logic        ex_we, ex_is_load;
   logic [4:0]  ex_rd;
   logic [31:0] ex_data;
   logic        mem_we;
   logic [4:0]  mem_rd;
   logic [31:0] mem_data;
   logic        out_valid, out_ready;
   logic [31:0] out_op1, out_op2, out_imm;
   logic [4:0]  out_rd;
   logic        out_rd_we, out_is_load;
   logic [15:0] stall_count;

   logic [31:0] bank [32];

   typedef struct packed {
      logic [31:0] op1;
      logic [31:0] op2;
      logic [4:0]  rd;
      logic        we;
      logic        ld;
      logic [31:0] imm;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clock = ~clock;

   assign rdata1 = bank[read_addr1];
   assign rdata2 = bank[read_addr2];

   operand_fetch_stage #(.XLEN(32), .AW(5), .STALL_CNT_W(16)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
      .in_is_load(in_is_load), .in_imm(in_imm),
      .read_addr1(read_addr1), .read_addr2(read_addr2),
      .rdata1(rdata1), .rdata2(rdata2),
      .ex_we(ex_we), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_data(ex_data),
      .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd),
      .out_rd_we(out_rd_we), .out_is_load(out_is_load), .out_imm(out_imm),
      .stall_count(stall_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every slot transfer to EX is checked against the oldest expectation.
   always @(negedge clock) begin : monitor
      exp_t e;
      if (reset === 1'b0 && flush === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL slot_unexpected: got op1=%h op2=%h expected no output", out_op1, out_op2);
         end else begin
            e = sb.pop_front();
            if ({out_op1, out_op2, out_rd, out_rd_we, out_is_load, out_imm} !== e) begin
               miscompares++;
               $display("FAIL slot: got op1=%h op2=%h rd=%0d we=%b ld=%b imm=%h expected op1=%h op2=%h rd=%0d we=%b ld=%b imm=%h",
                        out_op1, out_op2, out_rd, out_rd_we, out_is_load, out_imm,
                        e.op1, e.op2, e.rd, e.we, e.ld, e.imm);
            end
         end
      end
   end

   task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic we, input logic ld, input logic [31:0] imm);
      in_rs1     = rs1;
      in_rs2     = rs2;
      in_rd      = rd;
      in_rd_we   = we;
      in_is_load = ld;
      in_imm     = imm;
      in_valid   = 1'b1;
   endtask

   // Waits for the beat on the inputs to be accepted and records its expectation.
   task automatic wait_accept(input logic [31:0] e1, input logic [31:0] e2);
      int   n;
      exp_t e;
      n = 0;
      while (1) begin
         @(negedge clock);
         if (in_ready === 1'b1) begin
            e = '{op1: e1, op2: e2, rd: in_rd, we: in_rd_we, ld: in_is_load, imm: in_imm};
            sb.push_back(e);
            break;
         end
         n++;
         if (n > 20) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got in_ready=%b expected 1 within 20 cycles", in_ready);
            break;
         end
      end
      @(posedge clock);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      miscompares++;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 32; i++) bank[i] = i;
      bank[0] = 32'hDEADBEEF;
      bank[3] = 32'h1;
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd_we = 1'b0; in_is_load = 1'b0; in_imm = '0;
      ex_we = 1'b0; ex_rd = '0; ex_is_load = 1'b0; ex_data = '0;
      mem_we = 1'b0; mem_rd = '0; mem_data = '0;

      // reset values
      repeat (2) @(posedge clock);
      #1;
      chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
      chk("rst_op1", out_op1, 32'h0);
      chk("rst_op2", out_op2, 32'h0);
      chk("rst_rd", {27'b0, out_rd}, 32'h0);
      chk("rst_flags", {30'b0, out_rd_we, out_is_load}, 32'h0);
      chk("rst_imm", out_imm, 32'h0);
      chk("rst_stall", {16'b0, stall_count}, 32'h0);
      reset = 1'b0;

      // EX priority over MEM and bank
      @(posedge clock); #1;
      ex_we = 1'b1; ex_rd = 5'd3; ex_data = 32'hAAAA0000; ex_is_load = 1'b0;
      mem_we = 1'b1; mem_rd = 5'd3; mem_data = 32'h00005555;
      drive(5'd3, 5'd7, 5'd1, 1'b1, 1'b0, 32'h10);
      #1;
      chk("read_addr1", {27'b0, read_addr1}, 32'd3);
      chk("read_addr2", {27'b0, read_addr2}, 32'd7);
      wait_accept(32'hAAAA0000, 32'h7);

      // MEM forward on rs1, EX forward on rs2
      ex_rd = 5'd4;
      drive(5'd3, 5'd4, 5'd2, 1'b1, 1'b0, 32'hFFFFF800);
      wait_accept(32'h5555, 32'hAAAA0000);

      // x0 never forwarded, bank x0 ignored
      ex_rd = 5'd0; ex_data = 32'hFFFFFFFF; mem_we = 1'b0;
      drive(5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
      wait_accept(32'h2, 32'h0);
      drive(5'd0, 5'd6, 5'd11, 1'b1, 1'b0, 32'h3);
      wait_accept(32'h0, 32'h6);

      // load-use: one stall cycle, then MEM supplies the value
      ex_we = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5; ex_data = 32'h00000BAD;
      drive(5'd5, 5'd1, 5'd8, 1'b1, 1'b1, 32'h4);
      @(negedge clock);
      chk("loaduse_in_ready", {31'b0, in_ready}, 32'h0);
      @(posedge clock); #1;
      chk("loaduse_stall", {16'b0, stall_count}, 32'h1);
      ex_we = 1'b0; ex_is_load = 1'b0;
      mem_we = 1'b1; mem_rd = 5'd5; mem_data = 32'h1234;
      wait_accept(32'h1234, 32'h1);
      chk("loaduse_stall_after", {16'b0, stall_count}, 32'h1);

      // back-pressure: slot holds, in_ready low
      mem_we = 1'b0;
      @(posedge clock); #1;
      out_ready = 1'b0;
      drive(5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 32'h77);
      wait_accept(32'h1, 32'h2);
      drive(5'd6, 5'd7, 5'd10, 1'b0, 1'b1, 32'h55);
      repeat (3) begin
         @(negedge clock);
         chk("bp_in_ready", {31'b0, in_ready}, 32'h0);
         chk("bp_out_valid", {31'b0, out_valid}, 32'h1);
         chk("bp_op1", out_op1, 32'h1);
         chk("bp_op2", out_op2, 32'h2);
         chk("bp_imm", out_imm, 32'h77);
      end
      @(posedge clock); #1;
      out_ready = 1'b1;
      wait_accept(32'h6, 32'h7);

      // asynchronous reset with a held slot and nonzero stall count
      out_ready = 1'b0;
      ex_we = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5;
      drive(5'd5, 5'd0, 5'd1, 1'b1, 1'b0, 32'h0);
      @(posedge clock); #1;
      in_valid = 1'b0;
      chk("pre_rst_stall", {16'b0, stall_count}, 32'h2);
      chk("pre_rst_valid", {31'b0, out_valid}, 32'h1);
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("async_rst_valid", {31'b0, out_valid}, 32'h0);
      chk("async_rst_stall", {16'b0, stall_count}, 32'h0);
      chk("async_rst_op1", out_op1, 32'h0);
      chk("async_rst_in_ready", {31'b0, in_ready}, 32'h1);
      sb.delete();
      #2;
      reset = 1'b0;
      ex_we = 1'b0; ex_is_load = 1'b0;

      // flush drops the input beat
      @(posedge clock); #1;
      out_ready = 1'b1;
      flush = 1'b1;
      drive(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'h9);
      #1;
      chk("flush_in_ready", {31'b0, in_ready}, 32'h0);
      @(posedge clock); #1;
      chk("flush_out_valid", {31'b0, out_valid}, 32'h0);
      flush = 1'b0;
      in_valid = 1'b0;

      // flush and hazard together clear a held slot; hazard still counts
      out_ready = 1'b0;
      drive(5'd2, 5'd3, 5'd4, 1'b1, 1'b0, 32'h99);
      wait_accept(32'h2, 32'h1);
      ex_we = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5;
      flush = 1'b1;
      drive(5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 32'h0);
      #1;
      chk("flush_hz_in_ready", {31'b0, in_ready}, 32'h0);
      @(posedge clock); #1;
      chk("flush_hz_out_valid", {31'b0, out_valid}, 32'h0);
      chk("flush_hz_stall", {16'b0, stall_count}, 32'h1);
      void'(sb.pop_back());
      flush = 1'b0;

      // saturation
      repeat (65540) @(posedge clock);
      #1;
      chk("sat_stall", {16'b0, stall_count}, 32'hFFFF);
      chk("sat_out_valid", {31'b0, out_valid}, 32'h0);
      repeat (3) @(posedge clock);
      #1;
      chk("sat_hold", {16'b0, stall_count}, 32'hFFFF);
      in_valid = 1'b0;
      ex_we = 1'b0; ex_is_load = 1'b0;

      repeat (3) @(posedge clock);
      #1;
      chk("sb_empty", sb.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
